display_share_ctrl: RTL and testbench

Time-multiplexed owner of the 8-digit seven-segment display in the range-hood controller. Arbitrates among four display requesters (work-time counter, remind-time setter, countdown, cleaning-reminder flash), scans the granted source's eight BCD digits onto the two segment buses with anti-ghost blanking, and blanks everything when the hood is powered off. Sits between the mode/timer logic and the board's tub_segments/tub_select pins, replacing per-block scan logic.

---
 rtl/display_share_ctrl_pkg.sv | 31 +++
 rtl/display_share_ctrl_seg7_decode.sv | 11 +
 rtl/display_share_ctrl.sv | 169 ++++++++++++++++
 tb/tb_display_share_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/display_share_ctrl_pkg.sv
// Shared constants for seven-segment display blocks: segment codes, source indices and
// priority helpers used by the display arbiter.
package display_share_ctrl_pkg;

    localparam logic [7:0] SEG_BLANK = 8'b0000_0000;
    localparam logic [7:0] SEG_DASH  = 8'b0000_0010;

    // Indexed by nibble value; bit7 = segment a, bit0 = dp.
    localparam logic [15:0][7:0] SEG_LUT = {
        SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_DASH,
        8'b1110_0110, 8'b1111_1110, 8'b1110_0000, 8'b1011_1110, 8'b1011_0110,
        8'b0110_0110, 8'b1111_0010, 8'b1101_1010, 8'b0110_0000, 8'b1111_1100
    };

    localparam logic [1:0] SRC_WORK   = 2'd0;
    localparam logic [1:0] SRC_REMIND = 2'd1;
    localparam logic [1:0] SRC_COUNT  = 2'd2;
    localparam logic [1:0] SRC_ALERT  = 2'd3;

    function automatic logic [1:0] highest_src(input logic [3:0] req);
        if (req[3]) return SRC_ALERT;
        if (req[2]) return SRC_COUNT;
        if (req[1]) return SRC_REMIND;
        return SRC_WORK;
    endfunction

    function automatic logic [3:0] src_onehot(input logic [1:0] src);
        return 4'b0001 << src;
    endfunction

endpackage

// File: rtl/display_share_ctrl_seg7_decode.sv
// Nibble to seven-segment code: 0-9 digits, 0xA dash, 0xB-0xF blank.
module seg7_decode
    import display_share_ctrl_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_segments
);

    assign o_segments = SEG_LUT[i_nibble];

endmodule

// File: rtl/display_share_ctrl.sv
// Arbitrates four display requesters and scans the owner's eight digits onto the tube
// buses with a blanked lead-in per slot; grant only changes on frame boundaries.
module display_share_ctrl
    import display_share_ctrl_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 20000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned HOLD_FRAMES  = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_power_state,
    input  logic [3:0]   i_req,
    input  logic [127:0] i_digits,
    input  logic [31:0]  i_dmask,
    output logic [3:0]   o_grant,
    output logic [7:0]   o_tub_segments_1,
    output logic [7:0]   o_tub_segments_2,
    output logic [7:0]   o_tub_select,
    output logic         o_frame_done
);

    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    localparam logic [CW-1:0] CNT_ONE        = CW'(1);
    localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] CNT_PENULT     = CW'(SCAN_DIV - 2);
    localparam logic [CW-1:0] CNT_LAST       = CW'(SCAN_DIV - 1);
    localparam logic [HW-1:0] HOLD_INIT      = HW'(HOLD_FRAMES);
    localparam logic [HW-1:0] HOLD_ONE       = HW'(1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_slot;
    logic [HW-1:0] r_hold;
    logic [1:0]    r_owner;
    logic [3:0]    r_grant;
    logic [7:0]    r_seg1;
    logic [7:0]    r_seg2;
    logic [7:0]    r_sel;
    logic          r_frame_done;

    logic [2:0]    w_nib_idx;
    logic [3:0]    w_nibble;
    logic          w_digit_en;
    logic [7:0]    w_seg;
    logic [1:0]    w_top_src;
    logic [HW-1:0] w_hold_dec;
    logic          w_arb_idle;
    logic          w_arb_reload;
    logic [1:0]    w_arb_src;

    // Slot 0 is the leftmost digit, which lives in nibble 7.
    assign w_nib_idx  = 3'd7 - r_slot;
    assign w_nibble   = i_digits[{r_owner, w_nib_idx, 2'b00} +: 4];
    assign w_digit_en = i_dmask[{r_owner, w_nib_idx}];
    assign w_top_src  = highest_src(i_req);
    assign w_hold_dec = (r_hold == '0) ? '0 : r_hold - HOLD_ONE;

    seg7_decode u_seg7_decode (
        .i_nibble   (w_nibble),
        .o_segments (w_seg)
    );

    // Frame-end arbitration; only consumed on the last cycle of slot 7.
    always_comb begin
        w_arb_idle   = 1'b0;
        w_arb_reload = 1'b0;
        w_arb_src    = r_owner;
        if (!i_req[r_owner]) begin
            if (i_req == 4'd0) begin
                w_arb_idle = 1'b1;
            end else begin
                w_arb_src    = w_top_src;
                w_arb_reload = 1'b1;
            end
        end else if (w_hold_dec == '0 && w_top_src > r_owner) begin
            w_arb_src    = w_top_src;
            w_arb_reload = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_slot       <= 3'd0;
            r_hold       <= '0;
            r_owner      <= SRC_WORK;
            r_grant      <= 4'd0;
            r_seg1       <= SEG_BLANK;
            r_seg2       <= SEG_BLANK;
            r_sel        <= 8'd0;
            r_frame_done <= 1'b0;
        end else if (!i_power_state) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_slot       <= 3'd0;
            r_hold       <= '0;
            r_grant      <= 4'd0;
            r_seg1       <= SEG_BLANK;
            r_seg2       <= SEG_BLANK;
            r_sel        <= 8'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_req != 4'd0) begin
                        r_owner <= w_top_src;
                        r_grant <= src_onehot(w_top_src);
                        r_hold  <= HOLD_INIT;
                        r_slot  <= 3'd0;
                        r_cnt   <= '0;
                        r_state <= ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_BLANK_LAST) begin
                        r_state <= ST_DRIVE;
                        if (w_digit_en) begin
                            r_sel <= 8'h80 >> r_slot;
                            if (r_slot[2]) r_seg2 <= w_seg;
                            else           r_seg1 <= w_seg;
                        end
                    end
                end
                ST_DRIVE: begin
                    if (r_slot == 3'd7 && r_cnt == CNT_PENULT) r_frame_done <= 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_slot  <= r_slot + 3'd1;
                        r_seg1  <= SEG_BLANK;
                        r_seg2  <= SEG_BLANK;
                        r_sel   <= 8'd0;
                        r_state <= ST_BLANK;
                        if (r_slot == 3'd7) begin
                            if (w_arb_idle) begin
                                r_state <= ST_IDLE;
                                r_grant <= 4'd0;
                                r_hold  <= '0;
                            end else begin
                                r_owner <= w_arb_src;
                                r_grant <= src_onehot(w_arb_src);
                                r_hold  <= w_arb_reload ? HOLD_INIT : w_hold_dec;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_grant          = r_grant;
    assign o_tub_segments_1 = r_seg1;
    assign o_tub_segments_2 = r_seg2;
    assign o_tub_select     = r_sel;
    assign o_frame_done     = r_frame_done;

endmodule

// File: tb/tb_display_share_ctrl.sv
// Directed plus randomized bench for display_share_ctrl against a frame-level reference model.
module tb_display_share_ctrl;

    localparam int unsigned SD  = 8;
    localparam int unsigned BC  = 2;
    localparam int unsigned HF  = 2;
    localparam int          FRM = 8 * SD;

    logic         clk = 1'b0;
    logic         reset;
    logic         power_state;
    logic [3:0]   req;
    logic [127:0] digits;
    logic [31:0]  dmask;
    logic [3:0]   grant;
    logic [7:0]   seg1;
    logic [7:0]   seg2;
    logic [7:0]   sel;
    logic         frame_done;

    always #5 clk = ~clk;

    display_share_ctrl #(
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC),
        .HOLD_FRAMES  (HF)
    ) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_power_state    (power_state),
        .i_req            (req),
        .i_digits         (digits),
        .i_dmask          (dmask),
        .o_grant          (grant),
        .o_tub_segments_1 (seg1),
        .o_tub_segments_2 (seg2),
        .o_tub_select     (sel),
        .o_frame_done     (frame_done)
    );

    logic [7:0] seg_ref [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hE6, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    int         n_vec   = 0;
    int         n_err   = 0;
    int         m_owner = -1;
    int         m_hold  = 0;
    logic [31:0] m_dig [4];
    logic [7:0]  m_msk [4];

    function automatic int highest(input logic [3:0] r);
        for (int i = 3; i >= 0; i--) if (r[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input logic [3:0] eg, input logic [7:0] es1,
                                 input logic [7:0] es2, input logic [7:0] esel,
                                 input logic efd);
        chk("grant", 32'(grant), 32'(eg));
        chk("tub_segments_1", 32'(seg1), 32'(es1));
        chk("tub_segments_2", 32'(seg2), 32'(es2));
        chk("tub_select", 32'(sel), 32'(esel));
        chk("frame_done", 32'(frame_done), 32'(efd));
    endtask

    task automatic set_data();
        digits = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
        dmask  = {m_msk[3], m_msk[2], m_msk[1], m_msk[0]};
    endtask

    // Resolve who owns the coming frame, then check it cycle by cycle. An idle outcome
    // checks a single blank cycle. stop_cycle >= 0 returns early after that cycle.
    task automatic do_frame(input int mid_cycle, input logic [3:0] mid_req, input int stop_cycle);
        int s, k, ni;
        logic [3:0] nib;
        logic [7:0] eseg, es1, es2, esel;
        if (m_owner < 0) begin
            m_owner = highest(req);
            m_hold  = HF;
        end else begin
            m_hold = (m_hold > 0) ? m_hold - 1 : 0;
            if (!req[m_owner] || (m_hold == 0 && highest(req) > m_owner)) begin
                m_owner = highest(req);
                m_hold  = HF;
            end
        end
        if (m_owner < 0) begin
            @(posedge clk); #1;
            check_outputs(4'd0, 8'd0, 8'd0, 8'd0, 1'b0);
            return;
        end
        for (int c = 0; c < FRM; c++) begin
            @(posedge clk); #1;
            s    = c / SD;
            k    = c % SD;
            ni   = 7 - s;
            nib  = m_dig[m_owner][ni*4 +: 4];
            eseg = seg_ref[nib];
            es1  = 8'd0;
            es2  = 8'd0;
            esel = 8'd0;
            if (k >= BC && m_msk[m_owner][ni]) begin
                esel = 8'h80 >> s;
                if (s < 4) es1 = eseg;
                else       es2 = eseg;
            end
            check_outputs(4'b0001 << m_owner, es1, es2, esel, c == FRM - 1);
            if (c == mid_cycle) req = mid_req;
            if (c == stop_cycle) return;
        end
    endtask

    initial begin
        reset       = 1'b0;
        power_state = 1'b1;
        req         = 4'd0;
        for (int i = 0; i < 4; i++) begin
            m_dig[i] = 32'd0;
            m_msk[i] = 8'd0;
        end
        set_data();
        repeat (3) @(posedge clk);
        #1;
        check_outputs(4'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        reset = 1'b1;

        do_frame(-1, 4'd0, -1);
        do_frame(-1, 4'd0, -1);

        // Work-time source alone, full mask.
        m_dig[0] = 32'h0012_3045;
        m_msk[0] = 8'hFF;
        set_data();
        req = 4'b0001;
        do_frame(-1, 4'd0, -1);
        do_frame(-1, 4'd0, -1);
        req = 4'b0000;
        do_frame(-1, 4'd0, -1);

        // Fresh grant, higher request arrives mid-frame: held for two frames, then switch.
        m_dig[2] = 32'h9876_5432;
        m_msk[2] = 8'hFF;
        set_data();
        req = 4'b0001;
        do_frame(-1, 4'd0, -1);
        do_frame(20, 4'b0101, -1);
        do_frame(-1, 4'd0, -1);
        do_frame(30, 4'b0001, -1);

        // Owner 2 dropped; owner 0 returns with partial mask, dash and blank codes.
        m_dig[0] = 32'h1234_A5C7;
        m_msk[0] = 8'h0F;
        set_data();
        do_frame(-1, 4'd0, -1);

        for (int n = 0; n < 14; n++) begin
            for (int i = 0; i < 4; i++) begin
                m_dig[i] = $urandom;
                m_msk[i] = 8'($urandom);
            end
            set_data();
            if ($urandom_range(0, 3) != 0) req = 4'($urandom_range(0, 15));
            do_frame(int'($urandom_range(0, FRM - 1)), 4'($urandom_range(0, 15)), -1);
        end

        // Power drop in slot 7 drive, just before frame_done would pulse.
        req = 4'b0011;
        do_frame(-1, 4'd0, 62);
        power_state = 1'b0;
        m_owner     = -1;
        repeat (4) begin
            @(posedge clk); #1;
            check_outputs(4'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        end
        power_state = 1'b1;
        req         = 4'b1000;
        do_frame(-1, 4'd0, -1);

        // Asynchronous reset mid-frame.
        do_frame(-1, 4'd0, 20);
        #2 reset = 1'b0;
        #1 check_outputs(4'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        @(posedge clk); #1;
        check_outputs(4'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        reset   = 1'b1;
        m_owner = -1;
        do_frame(-1, 4'd0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
